segment_sequencer: RTL and testbench
====================================

# segment_sequencer

Controller that sequences the clock-segment FIFO into the variable-frequency clock generator. It starts a run on a soft trigger, or on a hard trigger when that option is compiled in. It loads 128-bit segment words with a one-deep prefetch so consecutive segments play back-to-back, and it parks on all-zero "wait for retrigger" words. It handles abort and end-of-list and reports progress to the host wire-outs and LEDs. It sits between the FIFO read port and the generator's counter datapath, all in the `refclk` domain.

## Interface
- `SEG_W`, 128: segment word width; fields are on[127:80], off[79:32], repeat[31:0]; this block does not interpret them.
- `CNT_W`, 16: width of `seg_count`.
- `refclk` in 1: reference clock; every flop uses its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_soft` in 1: one-cycle start pulse from the trigger endpoint.
- `abort` in 1: one-cycle abort pulse from the trigger endpoint.
- `use_hard_trig` in 1: level from the wire-in; selects hard-trigger arming.
- `hard_trig` in 1: asynchronous hard trigger input. Present only with `SEQ_HARD_TRIG_EN`.
- `retrigger` in 1: asynchronous retrigger input.
- `fifo_dout` in SEG_W: FIFO read data, valid 1 cycle after `fifo_rd_en`.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd_en` out 1: FIFO read strobe, one cycle per word.
- `fifo_rst` out 1: one-cycle FIFO reset pulse.
- `seg_data` out SEG_W: current segment presented to the generator.
- `seg_valid` out 1: `seg_data` is live and the generator may count.
- `seg_done` in 1: one-cycle pulse from the generator when the last repeat of the current segment ends.
- `gen_run` out 1: generator enable; when low, the generator clears its counters and holds its output low.
- `state` out 3: state encoding for the LEDs.
- `seg_count` out CNT_W: number of segments advanced in this run.
- `underrun` out 1: sticky flag, set when a prefetch miss occurs.
- `run_done` out 1: one-cycle pulse at normal end of list.

## Operation
- **Reset values:** all outputs are 0; `state` is IDLE; the shadow register is invalid.
- **States:** IDLE=0, ARM=1, FETCH=2, LOAD=3, RUN=4, WAIT_RT=5, DONE=6.
- **IDLE**
  - `start_soft` with `fifo_empty`=1 is ignored.
  - Otherwise go to ARM if `use_hard_trig` is set and the macro is compiled in; else go to FETCH.
  - Clear `seg_count` and `underrun` on start.
- **ARM:** a rising edge on synchronized `hard_trig` moves to FETCH.
- **FETCH:** assert `fifo_rd_en` for 1 cycle, then go to LOAD.
- **LOAD:** capture `fifo_dout` into `seg_data`. A zero word goes to WAIT_RT; a non-zero word goes to RUN.
- **RUN:** `seg_valid`=1 and `gen_run`=1.
  - **Prefetch:** when the shadow is invalid, no read is in flight and `fifo_empty`=0, assert `fifo_rd_en`. The word is captured into the shadow on the following cycle.
  - **Advance (on `seg_done`):**
    - Shadow valid: `seg_data`<=shadow, shadow invalidated, `seg_count`+1. Go to WAIT_RT if that word is zero, otherwise stay in RUN.
    - Shadow invalid with a read in flight: set `underrun`, drop `seg_valid` for 1 cycle, then advance using the arriving word.
    - Shadow invalid, no read in flight, FIFO empty: go to DONE.
- **WAIT_RT:** `seg_valid`=0 and `gen_run`=1.
  - The prefetch rules of RUN apply.
  - A rising edge on synchronized `retrigger` performs the advance, including the shadow-invalid cases.
- **DONE:** pulse `run_done` and `fifo_rst` for 1 cycle, drop `gen_run`, go to IDLE.
- **Abort:** `abort` in any non-IDLE state takes effect on the next edge:
  - state goes to IDLE;
  - `fifo_rst` pulses for 1 cycle;
  - `seg_valid`=0 and `gen_run`=0;
  - the shadow is invalidated and any in-flight read is discarded.
  - Abort has priority over a simultaneous `seg_done`, retrigger or start.
- **Counter wrap:** `seg_count` wraps modulo 2^CNT_W with no flag.

## Timing
- Outputs are registered.
- **Start-up latency:** `start_soft` sampled in cycle 0 gives `fifo_rd_en`=1 in cycle 1, LOAD in cycle 2, and `seg_valid`/`gen_run`=1 in cycle 3.
- **Synchronizers:** `hard_trig` and `retrigger` each pass through a 2-flop synchronizer plus edge detect, giving 3 cycles from pin to action. A pulse shorter than 1 `refclk` period may be missed.
- **Zero-gap advance:** `seg_done` in cycle N with a valid shadow updates `seg_data` in cycle N+1; `seg_valid` stays 1 throughout.
- **Minimum segment length:** a segment of at least 3 cycles guarantees the shadow is refilled before the next `seg_done`, provided the FIFO is non-empty.
- **Async reset:** `rst_n` low mid-run forces the reset values immediately, independent of `refclk`. No `fifo_rst` is issued; the FIFO has its own reset.

## Configuration
- **`SEQ_HARD_TRIG_EN` defined:**
  - the `hard_trig` port, its synchronizer and the ARM state exist;
  - `use_hard_trig`=1 routes start through ARM.
- **`SEQ_HARD_TRIG_EN` undefined:**
  - the `hard_trig` port is removed;
  - `use_hard_trig` is ignored;
  - ARM is unreachable and start always goes to FETCH.

## Test plan
- **Three-segment run:** load 3 non-zero words, pulse `start_soft`.
  - `seg_valid`=1 at cycle 3.
  - Each `seg_done` swaps `seg_data` the next cycle with no `seg_valid` drop.
  - `seg_count`=2 at the end, `run_done` and `fifo_rst` pulse once, then IDLE.
- **Retrigger wait:** words A, 0, B.
  - After A's `seg_done`, state=WAIT_RT and `seg_valid`=0.
  - A retrigger rising edge gives `seg_data`=B and `seg_valid`=1 three cycles later.
  - Holding `retrigger` high does not advance further.
- **Abort mid-RUN with shadow valid:** next cycle state=IDLE, `fifo_rst`=1 for 1 cycle, `gen_run`=0, and a following `seg_done` is ignored.
- **Start with empty FIFO:** state stays IDLE and `fifo_rd_en` stays 0.
- **Underrun:** feed 1-cycle segments (`seg_done` every cycle).
  - `underrun` is set, with a 1-cycle `seg_valid` gap.
  - All words are still delivered in order.
- **Hard-trigger arming (with `SEQ_HARD_TRIG_EN`):** `use_hard_trig`=1 and `start_soft`.
  - State stays ARM for 100 cycles.
  - A `hard_trig` edge gives `fifo_rd_en` 4 cycles later.
  - Rebuilt without the macro, the same stimulus goes straight to FETCH.

Source files
------------

// File: rtl/segment_sequencer.sv
// Sequences 128-bit clock segments from the FIFO into the clock generator.
// Define SEQ_HARD_TRIG_EN to build the hard_trig port and ARM state.
module segment_sequencer #(
   parameter int SEG_W = 128,
   parameter int CNT_W = 16
) (
   input  logic             refclk,
   input  logic             rst_n,
   input  logic             start_soft,
   input  logic             abort,
   input  logic             use_hard_trig,
`ifdef SEQ_HARD_TRIG_EN
   input  logic             hard_trig,
`endif
   input  logic             retrigger,
   input  logic [SEG_W-1:0] fifo_dout,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   output logic             fifo_rst,
   output logic [SEG_W-1:0] seg_data,
   output logic             seg_valid,
   input  logic             seg_done,
   output logic             gen_run,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] seg_count,
   output logic             underrun,
   output logic             run_done
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARM     = 3'd1,
      FETCH   = 3'd2,
      LOAD    = 3'd3,
      RUN     = 3'd4,
      WAIT_RT = 3'd5,
      DONE    = 3'd6
   } st_t;

   st_t              st_q, st_d;
   logic [SEG_W-1:0] seg_d, sh_q, sh_d, nxt;
   logic             shv_q, shv_d;
   logic             pend_q, pend_d;
   logic             advp_q, advp_d;
   logic             rd_d, frst_d, sv_d, run_d, ur_d, rdone_d;
   logic [CNT_W-1:0] cnt_d;
   logic [2:0]       rt_s;
   logic             rt_rise, ht_rise, hard_go;
   logic             adv_req, take_sh, take_do, consume;

   assign state   = st_q;
   assign rt_rise = rt_s[1] & ~rt_s[2];

`ifdef SEQ_HARD_TRIG_EN
   logic [2:0] ht_s;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) ht_s <= '0;
      else        ht_s <= {ht_s[1:0], hard_trig};
   end

   assign ht_rise = ht_s[1] & ~ht_s[2];
   assign hard_go = use_hard_trig;
`else
   logic unused_hard;
   assign unused_hard = use_hard_trig;
   assign ht_rise     = 1'b0;
   assign hard_go     = 1'b0;
`endif

   always_comb begin
      st_d    = st_q;
      seg_d   = seg_data;
      sh_d    = sh_q;
      shv_d   = shv_q;
      advp_d  = advp_q;
      pend_d  = 1'b0;
      rd_d    = 1'b0;
      frst_d  = 1'b0;
      rdone_d = 1'b0;
      sv_d    = seg_valid;
      run_d   = gen_run;
      ur_d    = underrun;
      cnt_d   = seg_count;
      adv_req = 1'b0;
      take_sh = 1'b0;
      take_do = 1'b0;
      consume = 1'b0;
      nxt     = '0;
      case (st_q)
         IDLE: begin
            if (start_soft && !fifo_empty) begin
               cnt_d  = '0;
               ur_d   = 1'b0;
               shv_d  = 1'b0;
               advp_d = 1'b0;
               if (hard_go) begin
                  st_d = ARM;
               end else begin
                  st_d = FETCH;
                  rd_d = 1'b1;
               end
            end
         end
         ARM: begin
            if (ht_rise) begin
               st_d = FETCH;
               rd_d = 1'b1;
            end
         end
         FETCH: st_d = LOAD;
         LOAD: begin
            seg_d = fifo_dout;
            run_d = 1'b1;
            sv_d  = (fifo_dout != '0);
            st_d  = (fifo_dout == '0) ? WAIT_RT : RUN;
            rd_d  = !fifo_empty;
         end
         RUN, WAIT_RT: begin
            // pend_q: the prefetch word is on fifo_dout this cycle
            pend_d = fifo_rd_en;
            if (pend_q && !advp_q) begin
               sh_d  = fifo_dout;
               shv_d = 1'b1;
            end
            if (st_q == RUN) adv_req = seg_done && seg_valid;
            else             adv_req = rt_rise;
            if (advp_q) begin
               take_sh = shv_q;
               take_do = !shv_q && pend_q;
            end else if (adv_req) begin
               if (shv_q) begin
                  take_sh = 1'b1;
               end else if (fifo_rd_en || pend_q || !fifo_empty) begin
                  ur_d   = 1'b1;
                  sv_d   = 1'b0;
                  advp_d = 1'b1;
               end else begin
                  st_d    = DONE;
                  sv_d    = 1'b0;
                  run_d   = 1'b0;
                  rdone_d = 1'b1;
                  frst_d  = 1'b1;
               end
            end
            consume = take_sh || take_do;
            if (consume) begin
               nxt    = take_sh ? sh_q : fifo_dout;
               seg_d  = nxt;
               shv_d  = 1'b0;
               advp_d = 1'b0;
               cnt_d  = seg_count + 1'b1;
               sv_d   = (nxt != '0);
               st_d   = (nxt == '0) ? WAIT_RT : RUN;
            end
            // refill as soon as the shadow is being emptied
            rd_d = !fifo_empty && !fifo_rd_en &&
                   (consume || (!shv_q && !pend_q));
         end
         DONE: st_d = IDLE;
         default: st_d = IDLE;
      endcase
      if (abort && st_q != IDLE) begin
         st_d    = IDLE;
         frst_d  = 1'b1;
         sv_d    = 1'b0;
         run_d   = 1'b0;
         shv_d   = 1'b0;
         pend_d  = 1'b0;
         advp_d  = 1'b0;
         rd_d    = 1'b0;
         rdone_d = 1'b0;
         seg_d   = seg_data;
         cnt_d   = seg_count;
         ur_d    = underrun;
      end
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         st_q       <= IDLE;
         seg_data   <= '0;
         sh_q       <= '0;
         shv_q      <= 1'b0;
         pend_q     <= 1'b0;
         advp_q     <= 1'b0;
         fifo_rd_en <= 1'b0;
         fifo_rst   <= 1'b0;
         seg_valid  <= 1'b0;
         gen_run    <= 1'b0;
         seg_count  <= '0;
         underrun   <= 1'b0;
         run_done   <= 1'b0;
         rt_s       <= '0;
      end else begin
         st_q       <= st_d;
         seg_data   <= seg_d;
         sh_q       <= sh_d;
         shv_q      <= shv_d;
         pend_q     <= pend_d;
         advp_q     <= advp_d;
         fifo_rd_en <= rd_d;
         fifo_rst   <= frst_d;
         seg_valid  <= sv_d;
         gen_run    <= run_d;
         seg_count  <= cnt_d;
         underrun   <= ur_d;
         run_done   <= rdone_d;
         rt_s       <= {rt_s[1:0], retrigger};
      end
   end

endmodule

// File: tb/tb_segment_sequencer.sv
// Bench for segment_sequencer: FIFO and generator models plus a segment scoreboard.
module tb_segment_sequencer;
   localparam int SEG_W = 128;
   localparam int CNT_W = 16;

   logic refclk = 1'b0;
   logic rst_n = 1'b0;
   logic start_soft = 1'b0;
   logic abort = 1'b0;
   logic use_hard_trig = 1'b0;
`ifdef SEQ_HARD_TRIG_EN
   logic hard_trig = 1'b0;
`endif
   logic retrigger = 1'b0;
   logic [SEG_W-1:0] fifo_dout = '0;
   logic fifo_empty = 1'b1;
   logic seg_done = 1'b0;
   logic fifo_rd_en, fifo_rst, seg_valid, gen_run, underrun, run_done;
   logic [SEG_W-1:0] seg_data;
   logic [2:0] state;
   logic [CNT_W-1:0] seg_count;

   int checks = 0;
   int errors = 0;
   logic [SEG_W-1:0] fifo_q[$];
   logic [SEG_W-1:0] exp_q[$];
   int len_lo = 3;
   int len_hi = 6;
   logic force_done = 1'b0;
   int gaps = 0, rd_seen = 0;
   int gcnt = 0, glen = 3;
   logic pv = 1'b0, pd = 1'b0;

   always #5 refclk = ~refclk;

   segment_sequencer #(.SEG_W(SEG_W), .CNT_W(CNT_W)) dut (
      .refclk(refclk), .rst_n(rst_n),
      .start_soft(start_soft), .abort(abort),
      .use_hard_trig(use_hard_trig),
`ifdef SEQ_HARD_TRIG_EN
      .hard_trig(hard_trig),
`endif
      .retrigger(retrigger),
      .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .fifo_rst(fifo_rst),
      .seg_data(seg_data), .seg_valid(seg_valid),
      .seg_done(seg_done), .gen_run(gen_run),
      .state(state), .seg_count(seg_count),
      .underrun(underrun), .run_done(run_done)
   );

   task automatic chk(input string name, input logic [SEG_W-1:0] act,
                      input logic [SEG_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   // FIFO (1-cycle read latency) and generator (random segment lengths)
   always @(posedge refclk) begin
      logic rd, frst, sv, gr;
      rd = fifo_rd_en;
      frst = fifo_rst;
      sv = seg_valid;
      gr = gen_run;
      #1;
      if (frst) fifo_q.delete();
      else if (rd && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
      if (!gr) begin
         gcnt = 0;
         glen = $urandom_range(len_hi, len_lo);
      end else if (sv) begin
         if (seg_done) begin
            gcnt = 0;
            glen = $urandom_range(len_hi, len_lo);
         end else gcnt++;
      end
      seg_done = force_done || (seg_valid && gen_run && gcnt == glen - 1);
   end

   // Scoreboard monitor: every newly presented segment pops the next expected word
   always @(negedge refclk) begin
      if (fifo_rd_en) rd_seen++;
      if (pv && !seg_valid && state == 3'd4) gaps++;
      if (seg_valid && (!pv || pd)) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL seg_extra got %0h want none", seg_data);
         end else chk("seg_data", seg_data, exp_q.pop_front());
      end
      pv = seg_valid;
      pd = seg_done;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge refclk);
      #2;
   endtask

   function automatic logic [SEG_W-1:0] rnd_word();
      return {$urandom, $urandom, $urandom, $urandom} | 128'd1;
   endfunction

   task automatic load_word(input logic [SEG_W-1:0] w);
      fifo_q.push_back(w);
      fifo_empty = 1'b0;
      if (w != '0) exp_q.push_back(w);
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
      int n = 0;
      do begin
         @(negedge refclk);
         n++;
      end while (state !== s && n < budget);
      checks++;
      if (state !== s) begin
         errors++;
         $display("FAIL %s timeout state %0d want %0d", tag, state, s);
      end
   endtask

   task automatic start_and_check(input string tag);
      tick();
      start_soft = 1'b1;
      tick();
      start_soft = 1'b0;
      @(negedge refclk);
      chk({tag, "_rd_c1"}, fifo_rd_en, 1);
      @(negedge refclk);
      chk({tag, "_load_c2"}, state, 3);
      @(negedge refclk);
      chk({tag, "_valid_c3"}, {seg_valid, gen_run}, 2'b11);
   endtask

   task automatic wait_done(input int cnt, input string tag);
      wait_state(3'd6, 3000, {tag, "_done"});
      chk({tag, "_run_done"}, {run_done, fifo_rst, gen_run}, 3'b110);
      chk({tag, "_count"}, seg_count, cnt);
      @(negedge refclk);
      chk({tag, "_idle"}, {state, run_done, fifo_rst}, 5'b0);
   endtask

   task automatic run_words(input int n, input bit ur, input string tag);
      int g0 = gaps;
      for (int i = 0; i < n; i++) load_word(rnd_word());
      start_and_check(tag);
      wait_done(n - 1, tag);
      chk({tag, "_underrun"}, underrun, ur);
      chk({tag, "_gaps"}, ur ? (gaps > g0) : (gaps == g0), 1);
      chk({tag, "_sb_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [SEG_W-1:0] wa, wb, wc;
      int r0, k;
      repeat (3) @(negedge refclk);
      chk("rst_state", state, 0);
      chk("rst_flags", {fifo_rd_en, fifo_rst, seg_valid, gen_run, underrun, run_done}, 0);
      chk("rst_data", seg_data, 0);
      chk("rst_count", seg_count, 0);
      tick();
      rst_n = 1'b1;

      // start with an empty FIFO is ignored
      r0 = rd_seen;
      tick();
      start_soft = 1'b1;
      tick();
      start_soft = 1'b0;
      tick(5);
      chk("empty_state", state, 0);
      chk("empty_rd", rd_seen - r0, 0);

      run_words(3, 1'b0, "three");

      // retrigger wait: A, 0, B, 0, C
      wa = rnd_word();
      wb = rnd_word();
      wc = rnd_word();
      load_word(wa);
      load_word('0);
      load_word(wb);
      load_word('0);
      load_word(wc);
      start_and_check("rt");
      wait_state(3'd5, 200, "rt_wait1");
      chk("rt_wait_valid", {seg_valid, gen_run}, 2'b01);
      tick(4);
      retrigger = 1'b1;
      @(negedge refclk);
      @(negedge refclk);
      @(negedge refclk);
      chk("rt_c2_valid", seg_valid, 0);
      @(negedge refclk);
      chk("rt_c3_valid", seg_valid, 1);
      chk("rt_c3_data", seg_data, wb);
      wait_state(3'd5, 200, "rt_wait2");
      tick(20);
      chk("rt_hold", {state, seg_valid}, {3'd5, 1'b0});
      retrigger = 1'b0;
      tick(4);
      retrigger = 1'b1;
      wait_done(4, "rt");
      retrigger = 1'b0;
      chk("rt_sb_empty", exp_q.size(), 0);

      // abort mid-RUN with a valid shadow
      len_lo = 12;
      len_hi = 12;
      for (int i = 0; i < 6; i++) load_word(rnd_word());
      start_and_check("ab");
      tick(6);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      @(negedge refclk);
      chk("ab_state", state, 0);
      chk("ab_flags", {fifo_rst, gen_run, seg_valid}, 3'b100);
      force_done = 1'b1;
      @(negedge refclk);
      force_done = 1'b0;
      chk("ab_rst_pulse", {state, fifo_rst}, 4'b0);
      tick(3);
      chk("ab_done_ignored", {state, seg_valid}, 4'b0);
      chk("ab_count", seg_count, 0);
      exp_q.delete();
      len_lo = 3;
      len_hi = 6;

      // underrun with 1-cycle segments
      len_lo = 1;
      len_hi = 1;
      run_words(6, 1'b1, "ur");
      len_lo = 3;
      len_hi = 6;

      for (int t = 0; t < 3; t++)
         run_words($urandom_range(10, 3), 1'b0, "rand");

      // asynchronous reset mid-run
      for (int i = 0; i < 5; i++) load_word(rnd_word());
      start_and_check("ar");
      tick(5);
      #1;
      rst_n = 1'b0;
      #1;
      chk("ar_state", state, 0);
      chk("ar_flags", {seg_valid, gen_run, fifo_rst, fifo_rd_en}, 0);
      chk("ar_count", seg_count, 0);
      fifo_q.delete();
      exp_q.delete();
      fifo_empty = 1'b1;
      tick();
      rst_n = 1'b1;

      // hard-trigger selection
      use_hard_trig = 1'b1;
`ifdef SEQ_HARD_TRIG_EN
      for (int i = 0; i < 3; i++) load_word(rnd_word());
      r0 = rd_seen;
      tick();
      start_soft = 1'b1;
      tick();
      start_soft = 1'b0;
      tick(100);
      chk("ht_arm", state, 1);
      chk("ht_no_rd", rd_seen - r0, 0);
      hard_trig = 1'b1;
      k = 0;
      do begin
         @(negedge refclk);
         k++;
      end while (!fifo_rd_en && k < 10);
      chk("ht_latency", k, 4);
      wait_done(2, "ht");
      hard_trig = 1'b0;
`else
      k = 0;
      for (int i = 0; i < 3; i++) load_word(rnd_word());
      start_and_check("nh");
      wait_done(2, "nh");
`endif
      use_hard_trig = 1'b0;
      chk("final_sb_empty", exp_q.size(), k - k);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
